// File: rtl/data_ram_resp_pkg.sv
// Shared constants for the data RAM responder: default depth, FSM encodings, lane layout.
// Build option DRAM_PARITY_EN widens each lane by one even-parity bit.
package data_ram_resp_pkg;

  localparam int DRAM_ADDR_WIDTH = 12;
  localparam int DRAM_LANES      = 4;

`ifdef DRAM_PARITY_EN
  localparam int DRAM_LANE_W = 9;
`else
  localparam int DRAM_LANE_W = 8;
`endif

  typedef enum logic {
    DRAM_ST_FILL = 1'b0,
    DRAM_ST_RUN  = 1'b1
  } dram_state_e;

  // Stored lane image: {parity, byte} with parity, plain byte without.
  function automatic logic [DRAM_LANE_W-1:0] make_lane(input logic [7:0] b);
`ifdef DRAM_PARITY_EN
    return {^b, b};
`else
    return b;
`endif
  endfunction

endpackage

// File: rtl/data_ram_resp_bank.sv
// One byte lane of the data RAM: synchronous write, registered read-first port.
// Width comes from DRAM_LANE_W, so DRAM_PARITY_EN builds carry the parity bit here.
module dram_byte_bank #(
  parameter int ADDR_WIDTH = 12,
  parameter int DW         = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [DW-1:0]         wdata,
  output logic [DW-1:0]         rdata
);

  logic [DW-1:0] mem_q [2**ADDR_WIDTH];
  logic [DW-1:0] rdata_q;

  // No reset on the array or read register so the pair maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_ram_resp.sv
// Responder for the EXE-stage data RAM: 4 byte-writable lanes, 1-cycle read, post-reset zero fill.
// Build option DRAM_PARITY_EN adds per-lane parity storage and the data_ram_r_perr output.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH    = DRAM_ADDR_WIDTH,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_ram_en,
  input  logic [31:0] data_ram_addr,
  input  logic [3:0]  data_ram_w_en,
  input  logic [31:0] data_ram_w_data,
  output logic [31:0] data_ram_r_data,
  output logic        data_ram_r_valid,
  output logic        init_done
`ifdef DRAM_PARITY_EN
  ,
  output logic [3:0]  data_ram_r_perr
`endif
);

  localparam dram_state_e           RESET_ST = INIT_ON_RESET ? DRAM_ST_FILL : DRAM_ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  dram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  r_valid_q, r_valid_d;
  logic                  rd_seen_q, rd_seen_d;

  logic                   fill_active, req_acc, rd_acc;
  logic [ADDR_WIDTH-1:0]  bank_addr;
  logic [DRAM_LANES-1:0]  bank_we;
  logic [DRAM_LANE_W-1:0] bank_wdata [DRAM_LANES];
  logic [DRAM_LANE_W-1:0] bank_rdata [DRAM_LANES];
  logic [31:0]            rd_word;
  logic                   unused_addr;

  assign unused_addr = ^{data_ram_addr[31:ADDR_WIDTH+2], data_ram_addr[1:0]};

  // Request protocol: en is a one-cycle strobe with no back-pressure; in RUN every
  // strobe is taken, w_en==0 marks a load, and r_valid pulses exactly one cycle later.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    fill_active = (state_q == DRAM_ST_FILL);
    req_acc     = !fill_active && data_ram_en;
    rd_acc      = req_acc && (data_ram_w_en == 4'b0000);
    r_valid_d   = rd_acc;
    rd_seen_d   = rd_seen_q | rd_acc;
    bank_addr   = fill_active ? cnt_q : data_ram_addr[ADDR_WIDTH+1:2];

    case (state_q)
      DRAM_ST_FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = DRAM_ST_RUN;
          init_done_d = 1'b1;
        end
      end
      default: ;
    endcase

    for (int i = 0; i < DRAM_LANES; i++) begin
      bank_we[i]    = fill_active | (req_acc & data_ram_w_en[i]);
      bank_wdata[i] = fill_active ? '0 : make_lane(data_ram_w_data[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RESET_ST;
      cnt_q       <= '0;
      init_done_q <= !INIT_ON_RESET;
      r_valid_q   <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      r_valid_q   <= r_valid_d;
      rd_seen_q   <= rd_seen_d;
    end
  end

  for (genvar g = 0; g < DRAM_LANES; g++) begin : g_lane
    dram_byte_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DW         (DRAM_LANE_W)
    ) u_bank (
      .clk   (clk),
      .addr  (bank_addr),
      .we    (bank_we[g]),
      .re    (rd_acc),
      .wdata (bank_wdata[g]),
      .rdata (bank_rdata[g])
    );
  end

  // The bank read registers are the output registers; rd_seen_q masks them to 0 after reset.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DRAM_LANES; i++) begin
      rd_word[8*i +: 8] = bank_rdata[i][7:0];
    end
  end

  assign data_ram_r_data  = rd_seen_q ? rd_word : 32'h0;
  assign data_ram_r_valid = r_valid_q;
  assign init_done        = init_done_q;

`ifdef DRAM_PARITY_EN
  always_comb begin
    data_ram_r_perr = '0;
    for (int i = 0; i < DRAM_LANES; i++) begin
      data_ram_r_perr[i] = r_valid_q & (^bank_rdata[i]);
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp (ADDR_WIDTH=4): directed scenarios plus random
// traffic against a word-array reference model with an expected-read queue.
module tb_data_ram_resp;

  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  wen = '0;
  logic [31:0] wdata = '0;
  logic [31:0] r_data;
  logic        r_valid;
  logic        init_done;
`ifdef DRAM_PARITY_EN
  logic [3:0]  r_perr;
`endif

  always #5 clk = ~clk;

  data_ram_resp #(
    .ADDR_WIDTH    (AW),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_ram_en      (en),
    .data_ram_addr    (addr),
    .data_ram_w_en    (wen),
    .data_ram_w_data  (wdata),
    .data_ram_r_data  (r_data),
    .data_ram_r_valid (r_valid),
    .init_done        (init_done)
`ifdef DRAM_PARITY_EN
    ,
    .data_ram_r_perr  (r_perr)
`endif
  );

  logic [31:0] model [DEPTH];
  bit          model_run;
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  logic        exp_valid;
  logic [31:0] exp_data;
  int          n_checks = 0;
  int          n_pass = 0;

  // Drives one request for one cycle and leaves the bench 1ns after the capturing edge.
  task automatic do_req(input logic r_en, input logic [31:0] r_addr,
                        input logic [3:0] r_wen, input logic [31:0] r_wdata);
    int idx;
    @(negedge clk);
    en = r_en; addr = r_addr; wen = r_wen; wdata = r_wdata;
    idx = int'(r_addr[AW+1:2]);
    exp_valid = 1'b0;
    if (model_run && r_en) begin
      if (r_wen == 4'b0000) begin
        exp_q.push_back(model[idx]);
        exp_valid = 1'b1;
      end else begin
        for (int l = 0; l < 4; l++)
          if (r_wen[l]) model[idx][8*l +: 8] = r_wdata[8*l +: 8];
      end
    end
    @(posedge clk);
    #1;
    if (exp_valid) last_rd = exp_q.pop_front();
    exp_data = last_rd;
  endtask

  task automatic apply_reset(input bit poke);
    int n;
    bit done;
    en = 1'b0; wen = '0;
    #1 resetn = 1'b0;
    #1;
    n_checks++; if (r_valid !== 1'b0) $display("FAIL reset_r_valid: got %0b want 0", r_valid); else n_pass++;
    n_checks++; if (r_data !== 32'h0) $display("FAIL reset_r_data: got %h want 00000000", r_data); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %0b want 0", init_done); else n_pass++;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    model_run = 1'b0;
    exp_q.delete();
    last_rd = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      if (poke && n == 5) begin
        en = 1'b1; addr = 32'h0; wen = 4'hF; wdata = 32'hFFFF_FFFF;
      end else if (poke && n == 6) begin
        en = 1'b1; addr = 32'h0; wen = 4'h0;
      end else begin
        en = 1'b0; wen = 4'h0;
      end
      @(posedge clk);
      #1;
      n++;
      n_checks++; if (r_valid !== 1'b0) $display("FAIL fill_r_valid: cycle %0d got %0b want 0", n, r_valid); else n_pass++;
      if (init_done === 1'b1) done = 1'b1;
    end
    en = 1'b0;
    n_checks++; if (n !== DEPTH || !done) $display("FAIL fill_length: init_done after %0d cycles want %0d", n, DEPTH); else n_pass++;
    model_run = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    do_req(1'b1, 32'h3C, 4'h0, 32'h0);
    n_checks++; if (r_valid !== 1'b1) $display("FAIL read_3c_valid: got %0b want 1", r_valid); else n_pass++;
    n_checks++; if (r_data !== 32'h0) $display("FAIL read_3c_data: got %h want 00000000", r_data); else n_pass++;
  endtask

  task automatic test_fill_drop();
    do_req(1'b1, 32'h0, 4'h0, 32'h0);
    n_checks++; if (r_valid !== 1'b1) $display("FAIL fill_drop_valid: got %0b want 1", r_valid); else n_pass++;
    n_checks++; if (r_data !== 32'h0) $display("FAIL fill_drop_data: got %h want 00000000", r_data); else n_pass++;
  endtask

  task automatic test_full_write();
    do_req(1'b1, 32'h20, 4'hF, 32'h1122_3344);
    n_checks++; if (r_valid !== 1'b0) $display("FAIL write_no_valid: got %0b want 0", r_valid); else n_pass++;
    do_req(1'b1, 32'h20, 4'h0, 32'h0);
    n_checks++; if (r_valid !== 1'b1) $display("FAIL full_read_valid: got %0b want 1", r_valid); else n_pass++;
    n_checks++; if (r_data !== 32'h1122_3344) $display("FAIL full_read_data: got %h want 11223344", r_data); else n_pass++;
`ifdef DRAM_PARITY_EN
    n_checks++; if (r_perr !== 4'h0) $display("FAIL full_read_perr: got %h want 0", r_perr); else n_pass++;
`endif
    do_req(1'b0, 32'h20, 4'h0, 32'h0);
    n_checks++; if (r_valid !== 1'b0) $display("FAIL full_idle_valid: got %0b want 0", r_valid); else n_pass++;
  endtask

  task automatic test_byte_store();
    do_req(1'b1, 32'h20, 4'b0100, 32'h00AA_0000);
    do_req(1'b1, 32'h20, 4'h0, 32'h0);
    n_checks++; if (r_valid !== 1'b1) $display("FAIL byte_read_valid: got %0b want 1", r_valid); else n_pass++;
    n_checks++; if (r_data !== 32'h11AA_3344) $display("FAIL byte_read_data: got %h want 11aa3344", r_data); else n_pass++;
    do_req(1'b1, 32'h20, 4'b1001, 32'h5566_7788);
    do_req(1'b1, 32'h23, 4'h0, 32'h0);
    n_checks++; if (r_data !== exp_data) $display("FAIL sparse_lane_data: got %h want %h", r_data, exp_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'hA0A0_0001; words[1] = 32'hB1B1_0002; words[2] = 32'hC2C2_0003;
    for (int i = 0; i < 3; i++) do_req(1'b1, 32'(4*i), 4'hF, words[i]);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 32'(4*i), 4'h0, 32'h0);
      n_checks++; if (r_valid !== 1'b1) $display("FAIL b2b_valid%0d: got %0b want 1", i, r_valid); else n_pass++;
      n_checks++; if (r_data !== words[i]) $display("FAIL b2b_data%0d: got %h want %h", i, r_data, words[i]); else n_pass++;
    end
    do_req(1'b0, 32'h0, 4'h0, 32'h0);
    n_checks++; if (r_valid !== 1'b0) $display("FAIL b2b_idle_valid: got %0b want 0", r_valid); else n_pass++;
    n_checks++; if (r_data !== words[2]) $display("FAIL b2b_idle_hold: got %h want %h", r_data, words[2]); else n_pass++;
  endtask

  task automatic test_random();
    logic        t_en;
    logic [3:0]  t_wen;
    for (int i = 0; i < 300; i++) begin
      t_en  = ($urandom_range(0, 3) != 0);
      t_wen = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      do_req(t_en, $urandom, t_wen, $urandom);
      n_checks++; if (r_valid !== exp_valid) $display("FAIL rand_valid[%0d]: got %0b want %0b", i, r_valid, exp_valid); else n_pass++;
      n_checks++; if (r_data !== exp_data) $display("FAIL rand_data[%0d]: got %h want %h", i, r_data, exp_data); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    do_req(1'b1, 32'h20, 4'hF, 32'hCAFE_F00D);
    do_req(1'b1, 32'h20, 4'h0, 32'h0);
    n_checks++; if (r_data !== 32'hCAFE_F00D) $display("FAIL pre_reset_data: got %h want cafef00d", r_data); else n_pass++;
    apply_reset(1'b0);
    do_req(1'b1, 32'h20, 4'h0, 32'h0);
    n_checks++; if (r_valid !== 1'b1) $display("FAIL post_reset_valid: got %0b want 1", r_valid); else n_pass++;
    n_checks++; if (r_data !== 32'h0) $display("FAIL post_reset_data: got %h want 00000000", r_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_drop();
    test_full_write();
    test_byte_store();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
